tx_framer: RTL and testbench

Transmit-side framer and serializer for one data lane: accepts parallel words of `2**STAGES` bits through a valid/ready handshake and drives one bit per `clk` onto the lane toward the pad driver. Each enable starts with a single `1` start-marker bit, which the receive deserializer uses to find word alignment. After the marker, words are sent back to back, LSB first, with no gaps. It sits between the link-layer transmit datapath and the TX driver, and mirrors the receive-side deserializer tree.

---
 rtl/tx_pkg.sv | 28 ++
 rtl/tx_skid_fifo.sv | 61 ++++++
 rtl/tx_framer.sv | 185 ++++++++++++++++++
 tb/tb_tx_framer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and PRBS7 helpers for the transmit lane framer.
// Latency: none (declarations only).
// Backpressure: not applicable.

`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

package tx_pkg;

  // Lane framing states: idle, one-bit start marker, word streaming.
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    MARK = 2'd1,
    RUN  = 2'd2
  } tx_state_e;

  // x^7 + x^6 + 1: feedback taps on the two oldest bits of the register.
  localparam logic [6:0] PRBS7_TAPS         = 7'b110_0000;
  localparam logic [6:0] PRBS7_SEED_DEFAULT = 7'h7F;

  // One PRBS7 step. Bit 0 of the result is the freshly generated bit,
  // bit 6 is the oldest bit still held.
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/tx_skid_fifo.sv
// Two-entry word FIFO used to decouple a TX lane from its producer.
// Latency: a pushed word is visible on rdata_o the cycle after the push edge.
// Backpressure: full_o high means a push is ignored; pop of an empty FIFO is ignored.

module tx_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overfilling or underrunning; callers may be sloppy.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: contents are only observable when count_q says so.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tx_framer.sv
// Serial TX framer: start marker then back-to-back LSB-first words (FIFO, PRBS7 or zero filler).
// Latency: word + en at edge k -> marker after edge k+1, bit 0 after edge k+2.
// Backpressure: din_ready follows FIFO not-full; starvation inserts zero filler, never a gap.

`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

module tx_framer
  import tx_pkg::*;
#(
  parameter int unsigned STAGES    = `SERDES_STAGES,
  parameter logic [6:0]  PRBS_SEED = PRBS7_SEED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2**STAGES-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 prbs_en,
  output logic                 dout,
  output logic                 word_strobe,
  output logic                 underflow,
  input  logic                 underflow_clr,
  output logic                 active
);

  localparam int unsigned       W        = 2**STAGES;
  localparam logic [STAGES-1:0] CNT_LAST = STAGES'(W - 1);

  tx_state_e         state_q, state_d;
  logic [W-1:0]      sr_q, sr_d;
  logic [STAGES-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic              dout_q, dout_d;
  logic              strobe_q, strobe_d;
  logic              underflow_q, underflow_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [W-1:0]      fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  logic [6:0]        lfsr_adv;
  logic [W-1:0]      prbs_word;
  logic              load;
  logic [W-1:0]      load_word;
  logic              underflow_set;

  // Ready is forced low during reset so nothing is accepted into a FIFO being cleared.
  assign din_ready = !fifo_full && !rst;
  assign fifo_push = din_valid && din_ready;

  tx_skid_fifo #(
    .WIDTH(W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .wdata_i(din),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Precompute the next W PRBS bits; bit 0 is the first bit generated.
  always_comb begin
    lfsr_adv  = lfsr_q;
    prbs_word = '0;
    for (int i = 0; i < W; i++) begin
      lfsr_adv     = prbs7_next(lfsr_adv);
      prbs_word[i] = lfsr_adv[0];
    end
  end

  // Next-state, serial datapath and word-load selection.
  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    lfsr_d        = lfsr_q;
    dout_d        = 1'b0;
    strobe_d      = 1'b0;
    fifo_pop      = 1'b0;
    load          = 1'b0;
    load_word     = '0;
    underflow_set = 1'b0;

    case (state_q)
      OFF: begin
        // A new start always emits a marker so the receiver can realign.
        if (en && (!fifo_empty || prbs_en)) begin
          state_d = MARK;
          dout_d  = 1'b1;
        end
      end
      MARK: begin
        state_d = RUN;
        load    = 1'b1;
      end
      RUN: begin
        if (bit_cnt_q == CNT_LAST) begin
          // Only word boundaries may stop the lane; a word is never truncated.
          if (!en) begin
            state_d   = OFF;
            bit_cnt_d = '0;
          end else begin
            load = 1'b1;
          end
        end else begin
          dout_d    = sr_q[0];
          sr_d      = sr_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase

    // PRBS wins over buffered data and leaves the FIFO alone; starvation sends zeros.
    if (load) begin
      if (prbs_en) begin
        load_word = prbs_word;
        lfsr_d    = lfsr_adv;
      end else if (!fifo_empty) begin
        load_word = fifo_rdata;
        fifo_pop  = 1'b1;
      end else begin
        load_word     = '0;
        underflow_set = 1'b1;
      end
      dout_d    = load_word[0];
      sr_d      = load_word >> 1;
      bit_cnt_d = '0;
      strobe_d  = 1'b1;
    end

    // A new underflow outranks a clear arriving in the same cycle.
    if (underflow_set) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift register, bit counter, LFSR and registered outputs; LFSR survives OFF periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      lfsr_q      <= PRBS_SEED;
      dout_q      <= 1'b0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      lfsr_q      <= lfsr_d;
      dout_q      <= dout_d;
      strobe_q    <= strobe_d;
      underflow_q <= underflow_d;
    end
  end

  assign dout        = dout_q;
  assign word_strobe = strobe_q;
  assign underflow   = underflow_q;
  assign active      = (state_q == MARK) || (state_q == RUN);

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer with W = 4.
// Latency: not applicable.
// Backpressure: the producer holds din/din_valid until din_ready is seen.

module tb_tx_framer;

  localparam int STAGES = 2;
  localparam int W      = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         prbs_en;
  logic         dout;
  logic         word_strobe;
  logic         underflow;
  logic         underflow_clr;
  logic         active;

  int total = 0;
  int bad   = 0;

  tx_framer #(
    .STAGES   (STAGES),
    .PRBS_SEED(7'h7F)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .prbs_en      (prbs_en),
    .dout         (dout),
    .word_strobe  (word_strobe),
    .underflow    (underflow),
    .underflow_clr(underflow_clr),
    .active       (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] word;
    logic [5:0] exp_dout;    // samples after push edge, leftmost first
    logic [5:0] exp_strobe;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    en            = 1'b0;
    din_valid     = 1'b0;
    din           = '0;
    prbs_en       = 1'b0;
    underflow_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    vec_t         vecs[5];
    logic [15:0]  got;
    logic [15:0]  got2;
    logic [3:0]   words[3];
    logic [3:0]   wbits;
    logic [3:0]   sbits;
    logic [3:0]   expw;
    logic [3:0]   cur;
    logic         rdy;
    logic         dropped;
    logic         uf_seen;
    logic         prev_dout;
    logic         seq[0:200];
    logic         dbits[0:199];
    logic [3:0]   exp_q[$];
    int           idx;
    int           mism;
    int           fillers;
    int           last_strobe;
    int           spacing_bad;
    int           nbits;

    vecs[0] = '{4'b1011, 6'b011101, 6'b001000};
    vecs[1] = '{4'b0001, 6'b011000, 6'b001000};
    vecs[2] = '{4'b1000, 6'b010001, 6'b001000};
    vecs[3] = '{4'b0110, 6'b010110, 6'b001000};
    vecs[4] = '{4'b1111, 6'b011111, 6'b001000};

    // Reset values, including din_ready while reset is held.
    rst = 1'b1; en = 1'b1; din_valid = 1'b1; din = 4'h3; prbs_en = 1'b0; underflow_clr = 1'b0;
    step();
    step();
    check("reset_outputs", {dout, word_strobe, underflow, active, din_ready}, 5'b00000);
    rst = 1'b0; din_valid = 1'b0; en = 1'b0;
    #1;
    check("ready_after_reset", din_ready, 1'b1);

    // Single-word vectors: marker, LSB-first data, strobe on bit 0, then filler.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      en = 1'b1; din = vecs[v].word; din_valid = 1'b1;
      got = '0; got2 = '0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (i == 0) din_valid = 1'b0;
        got  = {got[14:0], dout};
        got2 = {got2[14:0], word_strobe};
      end
      check($sformatf("vec%0d_dout", v), got[5:0], vecs[v].exp_dout);
      check($sformatf("vec%0d_strobe", v), got2[5:0], vecs[v].exp_strobe);
      check($sformatf("vec%0d_uf_before", v), underflow, 1'b0);
      step();
      check($sformatf("vec%0d_filler", v), {dout, word_strobe, underflow}, 3'b011);
    end

    // Back-to-back words with a producer that holds valid.
    do_reset();
    en = 1'b1; words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
    idx = 0; din = words[0]; din_valid = 1'b1; dropped = 1'b0; uf_seen = 1'b0; got = '0;
    for (int i = 0; i < 14; i++) begin
      rdy = din_ready;
      if (din_valid && !din_ready) dropped = 1'b1;
      step();
      if (din_valid && rdy) begin
        idx++;
        if (idx == 3) din_valid = 1'b0;
        else din = words[idx];
      end
      got     = {got[14:0], dout};
      uf_seen = uf_seen | underflow;
    end
    check("b2b_stream", got[13:0], 14'b01_0101_1010_1111);
    check("b2b_ready_dropped", dropped, 1'b1);
    check("b2b_no_underflow", uf_seen, 1'b0);

    // Disable mid-word, then re-enable with a word still buffered.
    do_reset();
    din = 4'hC; din_valid = 1'b1;
    step();
    din = 4'h3;
    step();
    din_valid = 1'b0;
    step();
    check("off_holds_idle", {dout, active}, 2'b00);
    en = 1'b1; got = '0; got2 = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 2) en = 1'b0;
      got  = {got[14:0], dout};
      got2 = {got2[14:0], active};
    end
    check("dis_dout", got[5:0], 6'b100110);
    check("dis_active", got2[5:0], 6'b111110);
    step();
    step();
    check("dis_stays_off", {dout, active}, 2'b00);
    en = 1'b1; got = '0; got2 = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      got  = {got[14:0], dout};
      got2 = {got2[14:0], word_strobe};
    end
    check("reen_dout", got[4:0], 5'b11100);
    check("reen_strobe", got2[4:0], 5'b01000);
    check("reen_no_underflow", underflow, 1'b0);

    // PRBS7 payload against the x^7+x^6+1 recurrence from an all-ones seed.
    for (int n = 0; n < 7; n++) seq[n] = 1'b1;
    for (int n = 0; n < 190; n++) seq[n + 7] = seq[n] ^ seq[n + 1];
    do_reset();
    din = 4'h9; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    check("prbs_idle_before_en", active, 1'b0);
    prbs_en = 1'b1; en = 1'b1;
    step();
    check("prbs_marker", {dout, active}, 2'b11);
    for (int w = 0; w < 35; w++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        wbits[j] = dout;
        sbits[j] = word_strobe;
        expw[j]  = seq[w * 4 + j + 7];
        dbits[w * 4 + j] = dout;
      end
      check($sformatf("prbs_word%0d", w), {sbits, wbits}, {4'b0001, expw});
    end
    mism = 0;
    for (int i = 0; i < 13; i++) if (dbits[i] !== dbits[i + 127]) mism++;
    check("prbs_period127", mism, 0);
    prbs_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      wbits[j] = dout;
      sbits[j] = word_strobe;
    end
    check("prbs_fifo_kept", {sbits, wbits}, {4'b0001, 4'h9});
    check("prbs_no_underflow", underflow, 1'b0);

    // Underflow set beats a simultaneous clear; a lone clear works.
    do_reset();
    en = 1'b1; din = 4'h5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (5) step();
    check("uf_clear_before", underflow, 1'b0);
    underflow_clr = 1'b1;
    step();
    check("uf_set_beats_clr", {underflow, word_strobe, dout}, 3'b110);
    step();
    underflow_clr = 1'b0;
    check("uf_lone_clr", underflow, 1'b0);

    // Reset in the middle of a word with the FIFO full.
    do_reset();
    en = 1'b1; words[0] = 4'h6; words[1] = 4'hB; words[2] = 4'hD;
    idx = 0; din = words[0]; din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdy = din_ready;
      step();
      if (din_valid && rdy) begin
        idx++;
        if (idx == 3) din_valid = 1'b0;
        else din = words[idx];
      end
    end
    check("rmid_busy_full", {active, din_ready}, 2'b10);
    rst = 1'b1;
    #1;
    check("rmid_ready_in_rst", din_ready, 1'b0);
    step();
    check("rmid_outputs", {dout, active, word_strobe, underflow}, 4'b0000);
    rst = 1'b0;
    #1;
    check("rmid_ready_after", din_ready, 1'b1);
    step();
    step();
    check("rmid_fifo_empty", {dout, active}, 2'b00);

    // Randomized producer; decode the serial stream and score it against pushed words.
    do_reset();
    en = 1'b1;
    exp_q.delete();
    fillers = 0; last_strobe = -1; spacing_bad = 0; nbits = W; cur = '0; prev_dout = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc < 600 && !din_valid && $urandom_range(0, 99) < 30) begin
        din       = 4'($urandom_range(1, 15));
        din_valid = 1'b1;
      end
      rdy = din_ready;
      step();
      if (din_valid && rdy) begin
        exp_q.push_back(din);
        din_valid = 1'b0;
      end
      if (word_strobe) begin
        if (last_strobe < 0) check("rnd_marker", prev_dout, 1'b1);
        else if (cyc - last_strobe != W) spacing_bad++;
        last_strobe = cyc;
        nbits = 0;
        cur = '0;
      end
      if (nbits < W) begin
        cur[nbits] = dout;
        nbits++;
        if (nbits == W) begin
          if (cur == 4'h0) fillers++;
          else begin
            expw = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
            check("rnd_word", cur, expw);
          end
        end
      end
      prev_dout = dout;
    end
    check("rnd_all_delivered", exp_q.size(), 0);
    check("rnd_spacing", spacing_bad, 0);
    check("rnd_underflow_flag", underflow, (fillers > 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
